// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request side and result/flags response side.
// The master drives requests and out_ready; the slave (the ALU) drives everything else.
interface alu_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   selec_alu;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         Neg;
    logic         Z;
    logic         C;
    logic         V;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_valid, a, b, selec_alu, out_ready,
        input  in_ready, result, result_hi, Neg, Z, C, V, out_valid
    );

    modport slave (
        input  in_valid, a, b, selec_alu, out_ready,
        output in_ready, result, result_hi, Neg, Z, C, V, out_valid
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: logic/add/sub in 1 cycle, shift-add mul and restoring div in N+1 cycles.
// One op in flight; in_ready only in IDLE, results held in DONE until out_ready.
module alu_seq #(
    parameter int N = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_q, res_d, res_hi_q, res_hi_d;
    logic          neg_q, neg_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic          accept, multi_in, last_step, is_div;
    logic [N:0]    sum, diff;
    logic [N-1:0]  s_res;
    logic          s_c, s_v;
    logic [N:0]    msum, rem_try;
    logic [N-1:0]  rem_sub, st_hi, st_lo;
    logic          q_bit;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign multi_in  = (bus.selec_alu == OP_MUL) || (bus.selec_alu == OP_DIV);
    assign last_step = (state_q == BUSY) && (cnt_q == CW'(1));
    assign is_div    = (op_q == OP_DIV);

    // Single-cycle ops are evaluated straight from the bus at the accept edge.
    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        diff  = {1'b0, bus.a} - {1'b0, bus.b};
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        unique case (bus.selec_alu)
            OP_ADD: begin
                s_res = sum[N-1:0];
                s_c   = sum[N];
                s_v   = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                s_res = diff[N-1:0];
                s_c   = ~diff[N];
                s_v   = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
            end
            OP_AND:  s_res = bus.a & bus.b;
            OP_OR:   s_res = bus.a | bus.b;
            OP_NOT:  s_res = ~bus.a;
            OP_XOR:  s_res = bus.a ^ bus.b;
            default: s_res = '0;
        endcase
    end

    // hi/lo double as product accumulator or as remainder/quotient shift pair.
    always_comb begin
        msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        rem_try = {hi_q, lo_q[N-1]};
        q_bit   = rem_try >= {1'b0, b_q};
        rem_sub = q_bit ? (rem_try[N-1:0] - b_q) : rem_try[N-1:0];
        if (is_div) begin
            st_hi = rem_sub;
            st_lo = {lo_q[N-2:0], q_bit};
        end else begin
            st_hi = msum[N:1];
            st_lo = {msum[0], lo_q[N-1:1]};
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        neg_d    = neg_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        if (accept) begin
            a_d  = bus.a;
            b_d  = bus.b;
            op_d = bus.selec_alu;
            if (multi_in) begin
                hi_d  = '0;
                lo_d  = (bus.selec_alu == OP_DIV) ? bus.a : bus.b;
                cnt_d = CW'(N);
            end else begin
                res_d    = s_res;
                res_hi_d = '0;
                neg_d    = s_res[N-1];
                z_d      = (s_res == '0);
                c_d      = s_c;
                v_d      = s_v;
            end
        end else if (state_q == BUSY) begin
            hi_d  = st_hi;
            lo_d  = st_lo;
            cnt_d = cnt_q - CW'(1);
            if (last_step) begin
                res_d    = st_lo;
                res_hi_d = st_hi;
                neg_d    = is_div ? 1'b0 : st_lo[N-1];
                z_d      = (st_lo == '0) && (st_hi == '0);
                c_d      = !is_div && (st_hi != '0);
                v_d      = is_div && (b_q == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            neg_q    <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            neg_q    <= neg_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = multi_in ? BUSY : DONE;
            BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = res_q;
        bus.result_hi = res_hi_q;
        bus.Neg       = neg_q;
        bus.Z         = z_q;
        bus.C         = c_q;
        bus.V         = v_q;
    end
endmodule
